// File: rtl/round_sequencer.sv
// round_sequencer
//
// Sequences one quiz level through four timed periods (prelim, game, answer,
// post), then waits in JUDGE for the judge result. A pass advances the level;
// a pass on the last level or any loss ends the game in OVER.
//
// Ports
//   Clk100M        in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   tick1Hz        in   one-cycle enable, once per second
//   startBtn       in   start request (honoured in IDLE and OVER only)
//   judgeValid     in   judge result strobe (honoured in JUDGE only)
//   judgeWin       in   1 = level passed, 0 = lost
//   pause          in   freezes the period timer (ROUND_SEQ_PAUSE_EN only)
//   pre/game/answer/post   out  one-hot period indicators
//   startGen/stopGen/stopCount/levelComplete  out  one-cycle entry pulses
//   secsLeft       out  seconds remaining in the current period
//   curLevel       out  current level index, 0-based
//   gameOver       out  game has ended
//   gameWon        out  outcome, valid while gameOver=1
//
// Optional feature: define ROUND_SEQ_PAUSE_EN to add the pause input.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | after reset, waiting for startBtn
// PRE     | prelim period, PRE_SECS ticks
// GAME    | game period, GAME_SECS ticks
// ANSWER  | answer period, ANS_SECS ticks
// POST    | post period, POST_SECS ticks
// JUDGE   | waiting for judgeValid
// OVER    | game finished, waiting for startBtn

module round_sequencer #(
  parameter int PRE_SECS   = 3,
  parameter int GAME_SECS  = 10,
  parameter int ANS_SECS   = 5,
  parameter int POST_SECS  = 3,
  parameter int CNT_W      = 4,
  parameter int NUM_LEVELS = 8,
  parameter int LVL_W      = 4
) (
  input  logic             Clk100M,
  input  logic             reset,
  input  logic             tick1Hz,
  input  logic             startBtn,
  input  logic             judgeValid,
  input  logic             judgeWin,
`ifdef ROUND_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic             pre,
  output logic             game,
  output logic             answer,
  output logic             post,
  output logic             startGen,
  output logic             stopGen,
  output logic             stopCount,
  output logic             levelComplete,
  output logic [CNT_W-1:0] secsLeft,
  output logic [LVL_W-1:0] curLevel,
  output logic             gameOver,
  output logic             gameWon
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_GAME, S_ANSWER, S_POST, S_JUDGE, S_OVER
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_SECS);
  localparam logic [CNT_W-1:0] GAME_LD = CNT_W'(GAME_SECS);
  localparam logic [CNT_W-1:0] ANS_LD  = CNT_W'(ANS_SECS);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_SECS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);

  state_t           state_q;
  logic             pre_q, game_q, answer_q, post_q;
  logic             start_gen_q, stop_gen_q, stop_count_q, level_complete_q;
  logic [CNT_W-1:0] secs_q;
  logic [LVL_W-1:0] level_q;
  logic             over_q, won_q;

  // A tick seen while paused is simply dropped, never remembered.
  logic tick_en;
`ifdef ROUND_SEQ_PAUSE_EN
  assign tick_en = tick1Hz & ~pause;
`else
  assign tick_en = tick1Hz;
`endif

  // Terminal count of the current timed period.
  logic secs_last;
  assign secs_last = (secs_q == ONE);

  always_ff @(posedge Clk100M or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      pre_q            <= 1'b0;
      game_q           <= 1'b0;
      answer_q         <= 1'b0;
      post_q           <= 1'b0;
      start_gen_q      <= 1'b0;
      stop_gen_q       <= 1'b0;
      stop_count_q     <= 1'b0;
      level_complete_q <= 1'b0;
      secs_q           <= '0;
      level_q          <= '0;
      over_q           <= 1'b0;
      won_q            <= 1'b0;
    end else begin
      start_gen_q      <= 1'b0;
      stop_gen_q       <= 1'b0;
      stop_count_q     <= 1'b0;
      level_complete_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // A coincident tick is not applied to the freshly loaded count.
          if (startBtn) begin
            state_q <= S_PRE;
            pre_q   <= 1'b1;
            secs_q  <= PRE_LD;
          end
        end

        S_PRE: begin
          if (tick_en) begin
            if (secs_last) begin
              state_q     <= S_GAME;
              pre_q       <= 1'b0;
              game_q      <= 1'b1;
              secs_q      <= GAME_LD;
              start_gen_q <= 1'b1;
            end else begin
              secs_q <= secs_q - ONE;
            end
          end
        end

        S_GAME: begin
          if (tick_en) begin
            if (secs_last) begin
              state_q    <= S_ANSWER;
              game_q     <= 1'b0;
              answer_q   <= 1'b1;
              secs_q     <= ANS_LD;
              stop_gen_q <= 1'b1;
            end else begin
              secs_q <= secs_q - ONE;
            end
          end
        end

        S_ANSWER: begin
          if (tick_en) begin
            if (secs_last) begin
              state_q      <= S_POST;
              answer_q     <= 1'b0;
              post_q       <= 1'b1;
              secs_q       <= POST_LD;
              stop_count_q <= 1'b1;
            end else begin
              secs_q <= secs_q - ONE;
            end
          end
        end

        S_POST: begin
          if (tick_en) begin
            if (secs_last) begin
              state_q          <= S_JUDGE;
              post_q           <= 1'b0;
              secs_q           <= '0;
              level_complete_q <= 1'b1;
            end else begin
              secs_q <= secs_q - ONE;
            end
          end
        end

        S_JUDGE: begin
          if (judgeValid) begin
            if (judgeWin && (level_q != LAST_LVL)) begin
              state_q <= S_PRE;
              pre_q   <= 1'b1;
              secs_q  <= PRE_LD;
              level_q <= level_q + LVL_W'(1);
            end else begin
              // Either the final level was passed or the level was lost.
              state_q <= S_OVER;
              over_q  <= 1'b1;
              won_q   <= judgeWin;
            end
          end
        end

        S_OVER: begin
          if (startBtn) begin
            state_q <= S_PRE;
            pre_q   <= 1'b1;
            secs_q  <= PRE_LD;
            level_q <= '0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          pre_q   <= 1'b0;
          game_q  <= 1'b0;
          answer_q <= 1'b0;
          post_q  <= 1'b0;
          secs_q  <= '0;
        end
      endcase
    end
  end

  assign pre           = pre_q;
  assign game          = game_q;
  assign answer        = answer_q;
  assign post          = post_q;
  assign startGen      = start_gen_q;
  assign stopGen       = stop_gen_q;
  assign stopCount     = stop_count_q;
  assign levelComplete = level_complete_q;
  assign secsLeft      = secs_q;
  assign curLevel      = level_q;
  assign gameOver      = over_q;
  assign gameWon       = won_q;

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, jv = 1'b0, jw = 1'b0;
`ifdef ROUND_SEQ_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic pre, game, answer, post;
  logic start_gen, stop_gen, stop_count, level_complete;
  logic [3:0] secs, level;
  logic over, won;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  round_sequencer #(.NUM_LEVELS(2)) dut (
    .Clk100M(clk), .reset(rst), .tick1Hz(tick), .startBtn(start),
    .judgeValid(jv), .judgeWin(jw),
`ifdef ROUND_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .pre(pre), .game(game), .answer(answer), .post(post),
    .startGen(start_gen), .stopGen(stop_gen), .stopCount(stop_count),
    .levelComplete(level_complete), .secsLeft(secs), .curLevel(level),
    .gameOver(over), .gameWon(won)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pre,game,answer,post, startGen,stopGen,stopCount,levelComplete, gameOver,gameWon}
  function automatic logic [9:0] flags();
    return {pre, game, answer, post, start_gen, stop_gen, stop_count,
            level_complete, over, won};
  endfunction

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic judge(input logic win);
    @(negedge clk) begin jv = 1'b1; jw = win; end
    @(negedge clk) begin jv = 1'b0; jw = 1'b0; end
  endtask

  initial begin
    // reset state
    #3;
    chk("reset_flags", flags(), 10'b0);
    chk("reset_secs", secs, 4'd0);
    chk("reset_level", level, 4'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("release_idle", {flags(), secs}, 14'd0);

    // tick in IDLE is ignored
    ticks(2);
    chk("idle_tick", {flags(), secs}, 14'd0);

    // prelim countdown 3,2,1 then game
    press_start();
    chk("pre_enter", {flags(), secs}, {10'b1000_0000_00, 4'd3});
    ticks(1);
    chk("pre_2", {pre, secs}, {1'b1, 4'd2});
    ticks(1);
    chk("pre_1", {pre, secs}, {1'b1, 4'd1});
    ticks(1);
    chk("game_enter", {flags(), secs}, {10'b0100_1000_00, 4'd10});
    @(negedge clk);
    chk("startGen_1cyc", {flags(), secs}, {10'b0100_0000_00, 4'd10});

    // game countdown to ANSWER after tick 13
    ticks(9);
    chk("game_1", {game, secs}, {1'b1, 4'd1});
    ticks(1);
    chk("answer_enter", {flags(), secs}, {10'b0010_0100_00, 4'd5});

    // start and judge strobes ignored outside IDLE/OVER/JUDGE
    press_start();
    chk("start_ignored", {flags(), secs}, {10'b0010_0000_00, 4'd5});
    judge(1'b1);
    chk("judge_ignored", {flags(), secs, level}, {10'b0010_0000_00, 4'd5, 4'd0});

    ticks(5);
    chk("post_enter", {flags(), secs}, {10'b0001_0010_00, 4'd3});
    ticks(3);
    chk("judge_enter", {flags(), secs}, {10'b0000_0001_00, 4'd0});
    ticks(2);
    chk("judge_tick_ignored", {flags(), secs}, {10'b0000_0000_00, 4'd0});

    // win at level 0 -> level 1
    judge(1'b1);
    chk("win_lvl0", {flags(), secs, level}, {10'b1000_0000_00, 4'd3, 4'd1});

    // full round, win final level -> game won
    ticks(21);
    chk("judge2_enter", {flags(), secs}, {10'b0000_0001_00, 4'd0});
    judge(1'b1);
    chk("game_won", {over, won, pre, secs}, {1'b1, 1'b1, 1'b0, 4'd0});

    // restart from OVER
    press_start();
    chk("restart", {flags(), secs, level}, {10'b1000_0000_00, 4'd3, 4'd0});

    // lose at level 0
    ticks(21);
    judge(1'b0);
    chk("game_lost", {flags(), secs, level}, {10'b0000_0000_10, 4'd0, 4'd0});

    // asynchronous reset mid-GAME at secsLeft=4
    press_start();
    ticks(3 + 6);
    chk("game_4", {game, secs}, {1'b1, 4'd4});
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {flags(), secs, level}, 18'd0);
    @(negedge clk) rst = 1'b0;
    ticks(2);
    chk("post_reset_ticks", {flags(), secs}, 14'd0);

    // start and tick coincide in IDLE: tick not consumed
    @(negedge clk) begin start = 1'b1; tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; tick = 1'b0; end
    chk("start_tick_coincide", {flags(), secs}, {10'b1000_0000_00, 4'd3});

`ifdef ROUND_SEQ_PAUSE_EN
    ticks(3 + 3);
    chk("pause_game_7", {game, secs}, {1'b1, 4'd7});
    @(negedge clk) pause = 1'b1;
    ticks(5);
    chk("paused_hold", {game, secs}, {1'b1, 4'd7});
    @(negedge clk) pause = 1'b0;
    ticks(6);
    chk("unpaused_1", {game, secs}, {1'b1, 4'd1});
    ticks(1);
    chk("pause_exit", {answer, stop_gen, secs}, {1'b1, 1'b1, 4'd5});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter PRE_SECS, default 3, prelim period length in 1 Hz ticks (legal range 1..2^CNT_W-1).
REQ-002 Parameter GAME_SECS, default 10, game period length in ticks.
REQ-003 Parameter ANS_SECS, default 5, answer period length in ticks.
REQ-004 Parameter POST_SECS, default 3, post period length in ticks.
REQ-005 Parameter CNT_W, default 4, width of the seconds counter.
REQ-006 Parameter NUM_LEVELS, default 8, number of levels; LVL_W, default 4, level index width.
REQ-007 Clk100M  in  1  sole clock; all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 tick1Hz  in  1  one-cycle enable, once per second, synchronous to Clk100M.
REQ-010 startBtn  in  1  one-cycle start request.
REQ-011 judgeValid  in  1  one-cycle strobe: the judge result is valid.
REQ-012 judgeWin  in  1  1 = level passed, 0 = lose; sampled only with judgeValid.
REQ-013 pause  in  1  freezes the timer (present only with ROUND_SEQ_PAUSE_EN).
REQ-014 pre, game, answer, post  out  1 each  one-hot period indicators; all 0 outside the four periods.
REQ-015 startGen, stopGen, stopCount, levelComplete  out  1 each  one-cycle pulses.
REQ-016 secsLeft  out  CNT_W  seconds remaining in the current period.
REQ-017 curLevel  out  LVL_W  current level index, 0-based.
REQ-018 gameOver  out  1  game has ended; gameWon  out  1  valid while gameOver=1.

Function
REQ-019 States: IDLE, PRE, GAME, ANSWER, POST, JUDGE, OVER; all outputs are registered.
REQ-020 IDLE->PRE on startBtn; startBtn is ignored in every state except IDLE and OVER.
REQ-021 On entering a timed state, secsLeft loads that state's *_SECS value; each tick1Hz decrements it by 1.
REQ-022 A timed state exits on the cycle where tick1Hz=1 and secsLeft=1; secsLeft never wraps below 1 inside a timed state.
REQ-023 Transitions: PRE->GAME, GAME->ANSWER, ANSWER->POST, POST->JUDGE.
REQ-024 Pulse mapping: startGen on entry to GAME, stopGen on entry to ANSWER, stopCount on entry to POST, levelComplete on entry to JUDGE.
REQ-025 Each pulse is asserted in the first cycle the new state is visible, for exactly one cycle.
REQ-026 secsLeft=0 in IDLE, JUDGE and OVER; tick1Hz is ignored in those states.
REQ-027 JUDGE waits indefinitely for judgeValid.
REQ-028 In JUDGE, judgeWin=1 and curLevel<NUM_LEVELS-1 -> curLevel+1 and go to PRE.
REQ-029 In JUDGE, judgeWin=1 and curLevel=NUM_LEVELS-1 -> OVER with gameWon=1.
REQ-030 In JUDGE, judgeWin=0 -> OVER with gameWon=0; curLevel is held.
REQ-031 judgeValid outside JUDGE is ignored.
REQ-032 OVER: gameOver=1; on startBtn, curLevel:=0, gameOver:=0, gameWon:=0, and go to PRE.
REQ-033 If tick1Hz and startBtn coincide in IDLE, enter PRE with secsLeft=PRE_SECS; the tick is not consumed.

Reset
REQ-034 Reset asserted, at any time including mid-period, forces IDLE with all outputs at 0 and curLevel=0, taking effect immediately and asynchronously.
REQ-035 Release is synchronous to the next Clk100M edge; no pulse is generated on release.

Configuration
REQ-036 Macro ROUND_SEQ_PAUSE_EN defined: the pause port exists, and pause=1 in a timed state suppresses decrement and exit while holding secsLeft and state.
REQ-037 With ROUND_SEQ_PAUSE_EN defined, tick1Hz while paused is discarded, not queued.
REQ-038 ROUND_SEQ_PAUSE_EN undefined: no pause port; timing follows REQ-021..022 only.

Verification
REQ-039 Defaults, startBtn, then 3 ticks -> pre=1 for 3 ticks with secsLeft 3,2,1; then game=1, secsLeft=10, and startGen high exactly 1 cycle.
REQ-040 Full round, 21 ticks after start -> stopGen after tick 13, stopCount after tick 18, levelComplete after tick 21, then JUDGE with secsLeft=0.
REQ-041 JUDGE with judgeValid=1, judgeWin=1 at curLevel=0 -> curLevel=1, PRE, secsLeft=3; with judgeWin=0 -> gameOver=1, gameWon=0, curLevel=0.
REQ-042 NUM_LEVELS=2, win both levels -> gameOver=1 and gameWon=1; then startBtn -> curLevel=0 and pre=1.
REQ-043 Reset asserted in GAME with secsLeft=4 -> all outputs 0 and IDLE before the next clock edge; ticks after release have no effect until startBtn.
REQ-044 With ROUND_SEQ_PAUSE_EN, pause=1 in GAME at secsLeft=7 for 5 ticks -> secsLeft stays 7; after release, exit to ANSWER after 7 more ticks.
